// File: rtl/bist_engine.sv
// bist_engine: built-in self-test engine for one scan-equipped CUT.
// A Fibonacci LFSR generates patterns, a shift/capture sequencer drives the
// scan chain, a MISR compacts CUT responses, and the final signature is
// compared against GOLDEN. All sequencing sits behind a start/end handshake.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_bist_start  session request (level-sampled)
//   i_bist_abort  terminates a running session
//   i_func_in     functional inputs, passed to the CUT when no session runs
//   i_resp        CUT responses (scan_out plus CUT outputs)
//   o_cut_in      CUT functional inputs after the pattern mux
//   o_scan_en     CUT scan enable
//   o_scan_in     CUT scan data input (LFSR MSB)
//   o_running     high in SHIFT, CAPTURE or COMPARE
//   o_bist_end    session finished
//   o_pass_fail   1 = signature matched GOLDEN
//   o_signature   current MISR contents
//
// state   | meaning
// IDLE    | waiting for start; functional inputs reach the CUT
// SHIFT   | scan_en high, LFSR advances, MISR compacts
// CAPTURE | one cycle, scan_en low, LFSR holds, MISR compacts
// COMPARE | one cycle, signature checked against GOLDEN
// DONE    | result held until start drops
module bist_engine #(
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'h01,
  parameter int                MISR_W    = 10,
  parameter logic [MISR_W-1:0] MISR_TAPS = 10'h240,
  parameter int                SCAN_LEN  = 16,
  parameter int                N_PAT     = 1000,
  parameter int                N_IN      = 3,
  parameter logic [MISR_W-1:0] GOLDEN    = 10'h000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bist_start,
  input  logic              i_bist_abort,
  input  logic [N_IN-1:0]   i_func_in,
  input  logic [MISR_W-1:0] i_resp,
  output logic [N_IN-1:0]   o_cut_in,
  output logic              o_scan_en,
  output logic              o_scan_in,
  output logic              o_running,
  output logic              o_bist_end,
  output logic              o_pass_fail,
  output logic [MISR_W-1:0] o_signature
);

  // A 1-deep counter would otherwise get zero width.
  localparam int SC_W = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam int PC_W = (N_PAT > 1) ? $clog2(N_PAT) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_LEN - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(N_PAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t            r_state, w_state_nx;
  logic [LFSR_W-1:0] r_lfsr, w_lfsr_nx, w_lfsr_step;
  logic [MISR_W-1:0] r_misr, w_misr_nx, w_misr_step;
  logic [SC_W-1:0]   r_shift_cnt, w_shift_nx;
  logic [PC_W-1:0]   r_pat_cnt, w_pat_nx;
  logic              r_bist_end, w_end_nx;
  logic              r_pass_fail, w_pf_nx;
  logic              w_active;

  assign w_lfsr_step = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
  assign w_misr_step = {r_misr[MISR_W-2:0], ^(r_misr & MISR_TAPS)} ^ i_resp;
  assign w_active    = (r_state == ST_SHIFT) || (r_state == ST_CAPTURE) ||
                       (r_state == ST_COMPARE);

  always_comb begin
    w_state_nx = r_state;
    w_lfsr_nx  = r_lfsr;
    w_misr_nx  = r_misr;
    w_shift_nx = r_shift_cnt;
    w_pat_nx   = r_pat_cnt;
    w_end_nx   = r_bist_end;
    w_pf_nx    = r_pass_fail;
    o_scan_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_bist_start) begin
          w_lfsr_nx  = LFSR_SEED;
          w_misr_nx  = '0;
          w_shift_nx = '0;
          w_pat_nx   = '0;
          w_end_nx   = 1'b0;
          w_pf_nx    = 1'b0;
          w_state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        o_scan_en = 1'b1;
        w_lfsr_nx = w_lfsr_step;
        w_misr_nx = w_misr_step;
        if (r_shift_cnt == SC_LAST) begin
          w_shift_nx = '0;
          w_state_nx = ST_CAPTURE;
        end else begin
          w_shift_nx = r_shift_cnt + SC_W'(1);
        end
      end
      ST_CAPTURE: begin
        w_misr_nx = w_misr_step;
        if (r_pat_cnt == PC_LAST) begin
          w_state_nx = ST_COMPARE;
        end else begin
          w_pat_nx   = r_pat_cnt + PC_W'(1);
          w_state_nx = ST_SHIFT;
        end
      end
      ST_COMPARE: begin
        w_pf_nx    = (r_misr == GOLDEN);
        w_end_nx   = 1'b1;
        w_state_nx = ST_DONE;
      end
      ST_DONE: begin
        // Start must drop before a new session can be requested.
        if (!i_bist_start) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase

    // Abort overrides everything above; LFSR/MISR freeze where they were.
    if (i_bist_abort && w_active) begin
      w_state_nx = ST_IDLE;
      w_lfsr_nx  = r_lfsr;
      w_misr_nx  = r_misr;
      w_shift_nx = '0;
      w_pat_nx   = '0;
      w_end_nx   = 1'b1;
      w_pf_nx    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_lfsr      <= LFSR_SEED;
      r_misr      <= '0;
      r_shift_cnt <= '0;
      r_pat_cnt   <= '0;
      r_bist_end  <= 1'b0;
      r_pass_fail <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_lfsr      <= w_lfsr_nx;
      r_misr      <= w_misr_nx;
      r_shift_cnt <= w_shift_nx;
      r_pat_cnt   <= w_pat_nx;
      r_bist_end  <= w_end_nx;
      r_pass_fail <= w_pf_nx;
    end
  end

  assign o_running   = w_active;
  assign o_cut_in    = w_active ? r_lfsr[N_IN-1:0] : i_func_in;
  assign o_scan_in   = r_lfsr[LFSR_W-1];
  assign o_bist_end  = r_bist_end;
  assign o_pass_fail = r_pass_fail;
  assign o_signature = r_misr;

endmodule

// File: tb/tb_bist_engine.sv
// Self-checking bench for bist_engine. A small reference model of the LFSR
// and MISR fills a per-cycle expectation queue and a per-session result
// queue when a session is started; the queues are drained as the DUT runs.
module tb_bist_engine;

  localparam int         SL    = 4;
  localparam int         NP    = 3;
  localparam int         SL2   = 300;
  localparam logic [7:0] TAPS  = 8'hB8;
  localparam logic [7:0] SEED  = 8'h01;
  localparam logic [9:0] MTAPS = 10'h240;
  localparam logic [9:0] GOLD  = 10'h000;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, start2;
  logic [2:0] func_in;
  logic [9:0] resp, resp2;

  logic [2:0] cut_in, cut_in2;
  logic       scan_en, scan_in, running, bist_end, pass_fail;
  logic       scan_en2, scan_in2, running2, bist_end2, pass_fail2;
  logic [9:0] signature, signature2;

  bist_engine #(
    .LFSR_W(8), .LFSR_TAPS(TAPS), .LFSR_SEED(SEED), .MISR_W(10),
    .MISR_TAPS(MTAPS), .SCAN_LEN(SL), .N_PAT(NP), .N_IN(3), .GOLDEN(GOLD)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_bist_start(start), .i_bist_abort(abort),
    .i_func_in(func_in), .i_resp(resp), .o_cut_in(cut_in), .o_scan_en(scan_en),
    .o_scan_in(scan_in), .o_running(running), .o_bist_end(bist_end),
    .o_pass_fail(pass_fail), .o_signature(signature)
  );

  // Long scan chain so the LFSR runs through more than one full period.
  bist_engine #(
    .LFSR_W(8), .LFSR_TAPS(TAPS), .LFSR_SEED(SEED), .MISR_W(10),
    .MISR_TAPS(MTAPS), .SCAN_LEN(SL2), .N_PAT(1), .N_IN(3), .GOLDEN(GOLD)
  ) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bist_start(start2), .i_bist_abort(1'b0),
    .i_func_in(func_in), .i_resp(resp2), .o_cut_in(cut_in2), .o_scan_en(scan_en2),
    .o_scan_in(scan_in2), .o_running(running2), .o_bist_end(bist_end2),
    .o_pass_fail(pass_fail2), .o_signature(signature2)
  );

  typedef struct packed {
    logic       scan_en;
    logic       running;
    logic       scan_in;
    logic [2:0] cut_in;
    logic [9:0] sig;
    logic       bend;
    logic       pf;
  } cyc_t;

  typedef struct packed {
    logic [9:0] sig;
    logic       pf;
  } res_t;

  cyc_t cyc_q[$];
  res_t res_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] lfsr_nx(input logic [7:0] l);
    return {l[6:0], ^(l & TAPS)};
  endfunction

  function automatic logic [9:0] misr_nx(input logic [9:0] m, input logic [9:0] r);
    return {m[8:0], ^(m & MTAPS)} ^ r;
  endfunction

  // Push the expected per-cycle outputs of one session and its final result.
  task automatic build_model(input logic [9:0] r);
    logic [7:0] l;
    logic [9:0] m;
    cyc_t       c;
    res_t       res;
    l = SEED;
    m = '0;
    for (int p = 0; p < NP; p++) begin
      for (int s = 0; s < SL; s++) begin
        c = '{scan_en: 1'b1, running: 1'b1, scan_in: l[7], cut_in: l[2:0],
              sig: m, bend: 1'b0, pf: 1'b0};
        cyc_q.push_back(c);
        l = lfsr_nx(l);
        m = misr_nx(m, r);
      end
      c = '{scan_en: 1'b0, running: 1'b1, scan_in: l[7], cut_in: l[2:0],
            sig: m, bend: 1'b0, pf: 1'b0};
      cyc_q.push_back(c);
      m = misr_nx(m, r);
    end
    c = '{scan_en: 1'b0, running: 1'b1, scan_in: l[7], cut_in: l[2:0],
          sig: m, bend: 1'b0, pf: 1'b0};
    cyc_q.push_back(c);
    res = '{sig: m, pf: (m == GOLD)};
    res_q.push_back(res);
  endtask

  // Start a session (pulse, or held high when hold=1) and check every cycle.
  task automatic run_checked(input logic [9:0] r, input bit hold, input string name);
    cyc_t e, o;
    res_t x;
    int   n;
    @(negedge clk);
    start   = 1'b1;
    resp    = r;
    func_in = 3'($urandom);
    build_model(r);
    @(negedge clk);
    if (!hold) start = 1'b0;
    n = 0;
    while (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      o = '{scan_en: scan_en, running: running, scan_in: scan_in, cut_in: cut_in,
            sig: signature, bend: bist_end, pf: pass_fail};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, n, o, e);
      end
      func_in = 3'($urandom);
      n++;
      @(negedge clk);
    end
    x = res_q.pop_front();
    checks++;
    if ({bist_end, pass_fail, signature, running} !== {1'b1, x.pf, x.sig, 1'b0}) begin
      errors++;
      $display("FAIL %s result: end=%b pf=%b sig=%h run=%b expected end=1 pf=%b sig=%h run=0",
               name, bist_end, pass_fail, signature, running, x.pf, x.sig);
    end
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    abort   = 1'b0;
    resp    = '0;
    resp2   = '0;
    func_in = 3'($urandom);
    repeat (2) @(negedge clk);
    checks++;
    if ({scan_en, running, bist_end, pass_fail, signature, scan_in} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 10'h000, SEED[7]}) begin
      errors++;
      $display("FAIL reset_values: en=%b run=%b end=%b pf=%b sig=%h si=%b expected all 0, si=%b",
               scan_en, running, bist_end, pass_fail, signature, scan_in, SEED[7]);
    end
    for (int i = 0; i < 3; i++) begin
      func_in = 3'($urandom);
      #1;
      checks++;
      if (cut_in !== func_in) begin
        errors++;
        $display("FAIL reset_cut_in: got %b expected %b", cut_in, func_in);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pass_session;
    run_checked(10'h000, 1'b0, "pass_session");
  endtask

  task automatic test_fail_session;
    run_checked(10'h001, 1'b0, "fail_session");
  endtask

  task automatic test_abort;
    @(negedge clk);
    start = 1'b1;
    resp  = 10'h001;
    @(negedge clk);
    start = 1'b0;
    // Cycles 5..8 after E0 are the shift of the second pattern.
    repeat (6) @(negedge clk);
    checks++;
    if ({running, scan_en} !== 2'b11) begin
      errors++;
      $display("FAIL abort_pre: run=%b en=%b expected 1 1", running, scan_en);
    end
    abort = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    func_in = 3'($urandom);
    #1;
    checks++;
    if ({running, scan_en, bist_end, pass_fail, cut_in} !== {1'b0, 1'b0, 1'b1, 1'b0, func_in}) begin
      errors++;
      $display("FAIL abort: run=%b en=%b end=%b pf=%b cut=%b expected 0 0 1 0 %b",
               running, scan_en, bist_end, pass_fail, cut_in, func_in);
    end
  endtask

  task automatic test_reset_midsession;
    @(negedge clk);
    start = 1'b1;
    resp  = 10'h001;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({running, scan_en, bist_end, pass_fail, signature, cut_in} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 10'h000, func_in}) begin
      errors++;
      $display("FAIL reset_midsession: run=%b en=%b end=%b pf=%b sig=%h cut=%b expected 0 0 0 0 000 %b",
               running, scan_en, bist_end, pass_fail, signature, cut_in, func_in);
    end
    resp = '0;
  endtask

  task automatic test_restart;
    run_checked(10'h000, 1'b1, "held_start_session");
    // Abort in DONE and a start held high must both leave the result alone.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({running, bist_end, pass_fail} !== 3'b011) begin
      errors++;
      $display("FAIL abort_in_done: run=%b end=%b pf=%b expected 0 1 1", running, bist_end, pass_fail);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({running, scan_en, bist_end} !== 3'b001) begin
        errors++;
        $display("FAIL no_restart %0d: run=%b en=%b end=%b expected 0 0 1", i, running, scan_en, bist_end);
      end
    end
    start = 1'b0;
    run_checked(10'h000, 1'b0, "restart_session");
  endtask

  task automatic test_lfsr_sequence;
    logic [7:0] m;
    bit         seen;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    m = SEED;
    for (int k = 0; k < SL2; k++) begin
      checks++;
      if ({scan_in2, cut_in2, scan_en2} !== {m[7], m[2:0], 1'b1}) begin
        errors++;
        $display("FAIL lfsr_seq step %0d: got si=%b cut=%b en=%b expected si=%b cut=%b en=1",
                 k, scan_in2, cut_in2, scan_en2, m[7], m[2:0]);
      end
      m = lfsr_nx(m);
      @(negedge clk);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bist_end2) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if ({seen, pass_fail2, signature2} !== {1'b1, 1'b1, 10'h000}) begin
      errors++;
      $display("FAIL lfsr_session_end: end_seen=%b pf=%b sig=%h expected 1 1 000",
               seen, pass_fail2, signature2);
    end
  endtask

  initial begin
    test_reset();
    test_pass_session();
    test_fail_session();
    test_abort();
    test_reset_midsession();
    test_restart();
    test_lfsr_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
